// File: rtl/radix4_booth_mul.sv
// -----------------------------------------------------------------------------
// radix4_booth_mul
//   Iterative radix-4 Booth multiply-accumulate: prod = a*b + r (all unsigned).
//   It rebuilds a dividend from an SRT divider's quotient, divisor and
//   remainder (N = Q*D + R). It retires one Booth digit per clock.
//   Digits are limited to -2..+2. They use the divider's 3-bit two's-complement
//   digit code.
//
// Parameters
//   W    operand width of a and b (even, 4..32)
//   RW   addend width of r (RW <= W)
//
// Ports
//   clk    in   1       rising-edge clock
//   reset  in   1       synchronous active-high reset
//   start  in   1       request, sampled only while idle
//   a      in   W       multiplier (Booth-recoded operand)
//   b      in   W       multiplicand
//   r      in   RW      addend
//   busy   out  1       high in CALC and DONE
//   done   out  1       one-cycle pulse when prod is valid
//   prod   out  2W+1    result, held until the next result is written
//   digit  out  3       Booth digit applied this cycle (000 outside CALC)
//
// Build option
//   RADIX4_MUL_EARLY_EXIT_EN : when defined, CALC ends as soon as the
//   remaining multiplier bits are all zero. At least one CALC cycle is always
//   spent. Results do not depend on this option.
// -----------------------------------------------------------------------------
module radix4_booth_mul #(
    parameter int W  = 6,
    parameter int RW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [RW-1:0]   r,
    output logic            busy,
    output logic            done,
    output logic [2*W:0]    prod,
    output logic [2:0]      digit
);

    localparam int NDIG = (W + 2) / 2;
    localparam int AW   = 2 * W + 3;
    localparam int MW   = W + 3;
    localparam int KW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [MW-1:0]   r_mreg;
    logic [AW-1:0]   r_mcand;
    logic [AW-1:0]   r_acc;
    logic [KW-1:0]   r_k;

    logic [2:0]      w_digit;
    logic [AW-1:0]   w_mcand_x2;
    logic [AW-1:0]   w_addend;
    logic [AW-1:0]   w_acc_next;
    logic [MW-1:0]   w_mreg_shift;
    logic            w_last;

    // Booth recoding of the low triple. The result is a 3-bit two's-complement digit.
    always_comb begin
        w_digit = 3'b000;
        case (r_mreg[2:0])
            3'b001, 3'b010: w_digit = 3'b001;   // +1
            3'b011:         w_digit = 3'b010;   // +2
            3'b100:         w_digit = 3'b110;   // -2
            3'b101, 3'b110: w_digit = 3'b111;   // -1
            default:        w_digit = 3'b000;   // 0
        endcase
    end

    assign w_mcand_x2 = {r_mcand[AW-2:0], 1'b0};

    // The negative partial products wrap modulo 2^AW. The running sum can go
    // negative in between, but the final sum is the true non-negative result.
    always_comb begin
        w_addend = '0;
        case (w_digit)
            3'b001:  w_addend = r_mcand;
            3'b010:  w_addend = w_mcand_x2;
            3'b111:  w_addend = '0 - r_mcand;
            3'b110:  w_addend = '0 - w_mcand_x2;
            default: w_addend = '0;
        endcase
    end

    assign w_acc_next   = r_acc + w_addend;
    assign w_mreg_shift = r_mreg >> 2;

`ifdef RADIX4_MUL_EARLY_EXIT_EN
    // No nonzero digit can follow once the shifted multiplier is all zeros.
    assign w_last = (r_k == KW'(NDIG - 1)) || (w_mreg_shift == '0);
`else
    assign w_last = (r_k == KW'(NDIG - 1));
`endif

    // Next-state logic and outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        digit        = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                busy  = 1'b1;
                digit = w_digit;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mreg  <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            prod    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mreg  <= {2'b00, a, 1'b0};
                        r_mcand <= AW'(b);
                        r_acc   <= AW'(r);
                        r_k     <= '0;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= {r_mcand[AW-3:0], 2'b00};
                    r_mreg  <= w_mreg_shift;
                    r_k     <= r_k + KW'(1);
                    if (w_last) begin
                        prod <= w_acc_next[2*W:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_booth_mul.sv
module tb_radix4_booth_mul;

    localparam int W    = 6;
    localparam int RW   = 4;
    localparam int NDIG = 4;
    localparam int TMO  = 20;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [RW-1:0]  r;
    logic           busy;
    logic           done;
    logic [2*W:0]   prod;
    logic [2:0]     digit;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [2*W:0] sb_q[$];
    logic [2:0]   dig_log[$];

    radix4_booth_mul #(.W(W), .RW(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .prod  (prod),
        .digit (digit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count of CALC cycles for a given multiplier
    function automatic int exp_lat(input logic [W-1:0] av);
`ifdef RADIX4_MUL_EARLY_EXIT_EN
        logic [W+2:0] m;
        m = {2'b00, av, 1'b0};
        for (int j = 1; j < NDIG; j++) begin
            if ((m >> (2 * j)) == '0) return j;
        end
        return NDIG;
`else
        return (av === av) ? NDIG : 0;
`endif
    endfunction

    // Called just after the accepting edge. Returns the edge count until done is seen.
    // Optionally pokes a start with other operands while busy.
    task automatic wait_done(input int poke, output int n);
        n = 0;
        while (done !== 1'b1 && n < TMO) begin
            if (busy === 1'b1) dig_log.push_back(digit);
            if (poke >= 0 && n == poke) begin
                start = 1'b1; a = 1; b = 1; r = 0;
            end else if (poke >= 0 && n == poke + 1) begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        if (n >= TMO) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [RW-1:0] rv, input int poke);
        int n;
        int e;
        start = 1'b1; a = av; b = bv; r = rv;
        e = int'(av) * int'(bv) + int'(rv);
        sb_q.push_back(e[2*W:0]);
        tick();
        start = 1'b0;
        dig_log.delete();
        chk("busy_accept", {31'd0, busy}, 32'd1);
        wait_done(poke, n);
        chk("latency", n, exp_lat(av));
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("digit_idle", {29'd0, digit}, 32'd0);
        if (sb_q.size() > 0) chk("prod", {19'd0, prod}, {19'd0, sb_q.pop_front()});
        $display("op a=%0d b=%0d r=%0d prod=%0d cycles=%0d", av, bv, rv, prod, n);
        tick();
        chk("done_fall", {31'd0, done}, 32'd0);
        chk("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; r = '0;
        tick();
        tick();
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_prod",  {19'd0, prod}, 32'd0);
        chk("rst_digit", {29'd0, digit}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Maximum operands
        run_op(6'd63, 6'd63, 4'd15, -1);
        chk("max_prod", {19'd0, prod}, 32'd3984);

        // Digit sequence for a=42
        run_op(6'd42, 6'd37, 4'd9, -1);
        chk("d_count", dig_log.size(), 32'd4);
        if (dig_log.size() == 4) begin
            chk("d0", {29'd0, dig_log[0]}, 32'b110);
            chk("d1", {29'd0, dig_log[1]}, 32'b111);
            chk("d2", {29'd0, dig_log[2]}, 32'b111);
            chk("d3", {29'd0, dig_log[3]}, 32'b001);
        end

        // Zero multiplier, where the latency depends on the build
        run_op(6'd0, 6'd55, 4'd7, -1);

        // Start while busy is ignored
        run_op(6'd63, 6'd63, 4'd15, 2);
        for (int i = 0; i < 6; i++) begin
            chk("no_extra_done", {31'd0, done}, 32'd0);
            tick();
        end
        chk("prod_hold", {19'd0, prod}, 32'd3984);

        // Reset mid-CALC
        start = 1'b1; a = 6'd63; b = 6'd63; r = 4'd15;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
        chk("mid_rst_done",  {31'd0, done}, 32'd0);
        chk("mid_rst_prod",  {19'd0, prod}, 32'd0);
        chk("mid_rst_digit", {29'd0, digit}, 32'd0);
        $display("reset mid-operation applied");
        reset = 1'b0;
        tick();
        run_op(6'd42, 6'd37, 4'd9, -1);

        // Back-to-back with start held high
        start = 1'b1; a = 6'd5; b = 6'd7; r = 4'd3;
        sb_q.push_back(13'd38);
        tick();
        a = 6'd9; b = 6'd11; r = 4'd2;
        sb_q.push_back(13'd101);
        wait_done(-1, n);
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_prod1", {19'd0, prod}, {19'd0, sb_q.pop_front()});
        $display("b2b op1 prod=%0d", prod);
        tick();
        chk("b2b_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("b2b_accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(-1, n);
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_prod2", {19'd0, prod}, {19'd0, sb_q.pop_front()});
        $display("b2b op2 prod=%0d", prod);
        tick();

        // Random sweep
        for (int i = 0; i < 2000; i++) begin
            run_op(W'($urandom_range(0, 63)), W'($urandom_range(0, 63)),
                   RW'($urandom_range(0, 15)), -1);
        end

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
